// File: rtl/axi_master_arbiter.sv
// ----------------------------------------------------------------------------
// axi_master_arbiter
//
// Shares one AXI4 master port (32-bit address, 64-bit data) between NREQ
// internal requesters (bit 0 = instruction fetch, bit 1 = load/store).
// Grants are round-robin and only one transaction is in flight at a time:
// a read runs AR -> R, a write runs AW -> W -> B. Response beats are steered
// back to the requester that owns the transaction.
//
// Parameters
//   NREQ  number of requesters (1..4)
//   IDW   AXI ID width; arid/awid carry the granted index, zero-extended
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      per-requester command handshake
//   req_write_i                    1 = write, 0 = read
//   req_addr_i / _size_i / _len_i  packed command fields, slice i per requester
//   wd_valid_i / wd_ready_o        per-requester write-data handshake
//   wd_data_i / wd_strb_i          packed write data and byte strobes
//   rsp_valid_o / rsp_ready_i      per-requester response handshake
//   rsp_data_o / _resp_o / _last_o shared response payload
//   axi_ar* axi_r* axi_aw* axi_w* axi_b*   AXI4 master channels
// ----------------------------------------------------------------------------
module axi_master_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // requester command side
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ-1:0]      req_write_i,
    input  logic [32*NREQ-1:0]   req_addr_i,
    input  logic [3*NREQ-1:0]    req_size_i,
    input  logic [8*NREQ-1:0]    req_len_i,
    // requester write data
    input  logic [NREQ-1:0]      wd_valid_i,
    output logic [NREQ-1:0]      wd_ready_o,
    input  logic [64*NREQ-1:0]   wd_data_i,
    input  logic [8*NREQ-1:0]    wd_strb_i,
    // requester responses
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [63:0]          rsp_data_o,
    output logic [1:0]           rsp_resp_o,
    output logic                 rsp_last_o,
    // AXI read address
    output logic                 axi_arvalid_o,
    input  logic                 axi_arready_i,
    output logic [31:0]          axi_araddr_o,
    output logic [IDW-1:0]       axi_arid_o,
    output logic [7:0]           axi_arlen_o,
    output logic [2:0]           axi_arsize_o,
    output logic [1:0]           axi_arburst_o,
    // AXI read data
    input  logic                 axi_rvalid_i,
    output logic                 axi_rready_o,
    input  logic [63:0]          axi_rdata_i,
    input  logic [1:0]           axi_rresp_i,
    input  logic                 axi_rlast_i,
    input  logic [IDW-1:0]       axi_rid_i,
    // AXI write address
    output logic                 axi_awvalid_o,
    input  logic                 axi_awready_i,
    output logic [31:0]          axi_awaddr_o,
    output logic [IDW-1:0]       axi_awid_o,
    output logic [7:0]           axi_awlen_o,
    output logic [2:0]           axi_awsize_o,
    output logic [1:0]           axi_awburst_o,
    // AXI write data
    output logic                 axi_wvalid_o,
    input  logic                 axi_wready_i,
    output logic [63:0]          axi_wdata_o,
    output logic [7:0]           axi_wstrb_o,
    output logic                 axi_wlast_o,
    // AXI write response
    input  logic                 axi_bvalid_i,
    output logic                 axi_bready_o,
    input  logic [1:0]           axi_bresp_i,
    input  logic [IDW-1:0]       axi_bid_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   rr_q;
    logic [IW-1:0]   grant_q;
    logic [31:0]     addr_q;
    logic [2:0]      size_q;
    logic [7:0]      len_q;
    logic [7:0]      beat_q;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] grant_oh;
    logic            sel_write;
    logic [31:0]     sel_addr;
    logic [2:0]      sel_size;
    logic [7:0]      sel_len;
    logic            g_wd_valid;
    logic [63:0]     g_wd_data;
    logic [7:0]      g_wd_strb;
    logic            g_rsp_ready;
    logic [IW-1:0]   rr_next;

    // Response IDs are not checked: only one transaction is ever outstanding.
    logic unused_ids;
    assign unused_ids = ^{axi_rid_i, axi_bid_i};

    // Round-robin pick: first requester at or above the pointer, otherwise
    // the first one below it (wrap-around).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req_valid_i[i] && (i >= int'(rr_q))) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req_valid_i[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end

    // Per-requester muxes: command fields of the candidate winner, data and
    // response handshakes of the current owner.
    always_comb begin
        win_oh      = '0;
        grant_oh    = '0;
        sel_write   = 1'b0;
        sel_addr    = '0;
        sel_size    = '0;
        sel_len     = '0;
        g_wd_valid  = 1'b0;
        g_wd_data   = '0;
        g_wd_strb   = '0;
        g_rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == win_idx) begin
                win_oh[i] = 1'b1;
                sel_write = req_write_i[i];
                sel_addr  = req_addr_i[i*32 +: 32];
                sel_size  = req_size_i[i*3 +: 3];
                sel_len   = req_len_i[i*8 +: 8];
            end
            if (IW'(i) == grant_q) begin
                grant_oh[i] = 1'b1;
                g_wd_valid  = wd_valid_i[i];
                g_wd_data   = wd_data_i[i*64 +: 64];
                g_wd_strb   = wd_strb_i[i*8 +: 8];
                g_rsp_ready = rsp_ready_i[i];
            end
        end
    end

    assign rr_next = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;

    // Transaction sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            case (state_q)
                ST_IDLE: begin
                    // req_ready is raised for the winner in this state, so a
                    // winner implies a completed command handshake.
                    if (win_found) begin
                        grant_q <= win_idx;
                        addr_q  <= sel_addr;
                        size_q  <= sel_size;
                        len_q   <= sel_len;
                        state_q <= sel_write ? ST_AW : ST_AR;
                    end
                end
                ST_AR: begin
                    if (axi_arready_i) state_q <= ST_R;
                end
                ST_R: begin
                    if (axi_rvalid_i && g_rsp_ready && axi_rlast_i) begin
                        state_q <= ST_IDLE;
                        rr_q    <= rr_next;
                    end
                end
                ST_AW: begin
                    if (axi_awready_i) begin
                        state_q <= ST_W;
                        beat_q  <= '0;
                    end
                end
                ST_W: begin
                    if (g_wd_valid && axi_wready_i) begin
                        if (beat_q == len_q) state_q <= ST_B;
                        else                 beat_q  <= beat_q + 8'd1;
                    end
                end
                ST_B: begin
                    if (axi_bvalid_i && g_rsp_ready) begin
                        state_q <= ST_IDLE;
                        rr_q    <= rr_next;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Address channels come straight from registered state and latched fields.
    assign axi_arvalid_o = (state_q == ST_AR);
    assign axi_araddr_o  = addr_q;
    assign axi_arid_o    = IDW'(grant_q);
    assign axi_arlen_o   = len_q;
    assign axi_arsize_o  = size_q;
    assign axi_arburst_o = 2'b01;

    assign axi_awvalid_o = (state_q == ST_AW);
    assign axi_awaddr_o  = addr_q;
    assign axi_awid_o    = IDW'(grant_q);
    assign axi_awlen_o   = len_q;
    assign axi_awsize_o  = size_q;
    assign axi_awburst_o = 2'b01;

    // Data/response channels pass through for the owner only.
    always_comb begin
        req_ready_o  = '0;
        wd_ready_o   = '0;
        rsp_valid_o  = '0;
        rsp_data_o   = '0;
        rsp_resp_o   = '0;
        rsp_last_o   = 1'b0;
        axi_rready_o = 1'b0;
        axi_bready_o = 1'b0;
        axi_wvalid_o = 1'b0;
        axi_wdata_o  = '0;
        axi_wstrb_o  = '0;
        axi_wlast_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Gated by rst_n so no requester sees ready while reset is held.
                if (win_found && rst_n) req_ready_o = win_oh;
            end
            ST_R: begin
                axi_rready_o = g_rsp_ready;
                rsp_valid_o  = axi_rvalid_i ? grant_oh : '0;
                rsp_data_o   = axi_rdata_i;
                rsp_resp_o   = axi_rresp_i;
                rsp_last_o   = axi_rlast_i;
            end
            ST_W: begin
                axi_wvalid_o = g_wd_valid;
                axi_wdata_o  = g_wd_data;
                axi_wstrb_o  = g_wd_strb;
                axi_wlast_o  = (beat_q == len_q);
                wd_ready_o   = axi_wready_i ? grant_oh : '0;
            end
            ST_B: begin
                axi_bready_o = g_rsp_ready;
                rsp_valid_o  = axi_bvalid_i ? grant_oh : '0;
                rsp_resp_o   = axi_bresp_i;
                rsp_last_o   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_master_arbiter.sv
module tb_axi_master_arbiter;
    localparam int N   = 2;
    localparam int IDW = 4;

    logic clk = 1'b0;
    logic rst_n;

    logic [N-1:0]    req_valid, req_ready, req_write;
    logic [32*N-1:0] req_addr;
    logic [3*N-1:0]  req_size;
    logic [8*N-1:0]  req_len;
    logic [N-1:0]    wd_valid, wd_ready;
    logic [64*N-1:0] wd_data;
    logic [8*N-1:0]  wd_strb;
    logic [N-1:0]    rsp_valid, rsp_ready;
    logic [63:0]     rsp_data;
    logic [1:0]      rsp_resp;
    logic            rsp_last;
    logic            arvalid, arready, rvalid, rready, rlast;
    logic [31:0]     araddr, awaddr;
    logic [IDW-1:0]  arid, awid, rid, bid;
    logic [7:0]      arlen, awlen, wstrb;
    logic [2:0]      arsize, awsize;
    logic [1:0]      arburst, awburst, rresp, bresp;
    logic [63:0]     rdata, wdata;
    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;

    always #5 clk = ~clk;

    axi_master_arbiter #(.NREQ(N), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_len_i(req_len),
        .wd_valid_i(wd_valid), .wd_ready_o(wd_ready), .wd_data_i(wd_data), .wd_strb_i(wd_strb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_resp_o(rsp_resp), .rsp_last_o(rsp_last),
        .axi_arvalid_o(arvalid), .axi_arready_i(arready), .axi_araddr_o(araddr),
        .axi_arid_o(arid), .axi_arlen_o(arlen), .axi_arsize_o(arsize), .axi_arburst_o(arburst),
        .axi_rvalid_i(rvalid), .axi_rready_o(rready), .axi_rdata_i(rdata),
        .axi_rresp_i(rresp), .axi_rlast_i(rlast), .axi_rid_i(rid),
        .axi_awvalid_o(awvalid), .axi_awready_i(awready), .axi_awaddr_o(awaddr),
        .axi_awid_o(awid), .axi_awlen_o(awlen), .axi_awsize_o(awsize), .axi_awburst_o(awburst),
        .axi_wvalid_o(wvalid), .axi_wready_i(wready), .axi_wdata_o(wdata),
        .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
        .axi_bvalid_i(bvalid), .axi_bready_o(bready), .axi_bresp_i(bresp), .axi_bid_i(bid)
    );

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;   // model's round-robin pointer

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_write = '0; req_addr = '0; req_size = '0; req_len = '0;
        wd_valid = '0; wd_data = '0; wd_strb = '0; rsp_ready = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_wd_ready"}, wd_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_valids"}, {arvalid, awvalid, wvalid}, 0);
        check({tag, "_readys"}, {rready, bready}, 0);
        check({tag, "_araddr"}, araddr, 0);
        check({tag, "_arlen_id"}, {arlen, arid, arsize}, 0);
        check({tag, "_wpayload"}, {wdata[31:0], wstrb, wlast}, 0);
        check({tag, "_bursts"}, {arburst, awburst}, 4'b0101);
    endtask

    typedef struct {
        int          who;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [63:0] data;       // beat b carries data + b
        int          addr_wait;  // cycles the address channel is held off
        int          stall_beat; // beat on which backpressure is applied (-1 none)
        int          stall;      // number of stall cycles on that beat
        int          resp_beat;  // read beat carrying a non-OKAY resp (-1 none)
        logic [1:0]  resp;       // slave resp for resp_beat, or bresp for writes
        logic [IDW-1:0] exp_id;
        logic [1:0]  exp_resp;
    } txn_t;

    // One complete transaction with only the owner requesting; the other
    // requester raises req_valid during the address phase and must wait.
    task automatic run_txn(input txn_t t);
        logic [N-1:0] oh;
        logic [63:0]  d;
        int           other;
        oh    = N'(1) << t.who;
        other = 1 - t.who;
        req_valid[t.who] = 1'b1;
        req_write[t.who] = t.wr;
        req_addr[t.who*32 +: 32] = t.addr;
        req_size[t.who*3 +: 3]   = t.size;
        req_len[t.who*8 +: 8]    = t.len;
        #1 check("cmd_ready", req_ready, oh);
        step();
        req_valid[t.who] = 1'b0;
        req_valid[other] = 1'b1;
        if (t.wr) begin
            wd_valid[t.who] = 1'b1;
            wd_data[t.who*64 +: 64] = t.data;
        end
        for (int i = 0; i <= t.addr_wait; i++) begin
            if (i == t.addr_wait) begin
                arready = !t.wr;
                awready = t.wr;
            end
            #1;
            check("busy_no_ready", req_ready, 0);
            if (t.wr) begin
                check("awvalid", {awvalid, arvalid}, 2'b10);
                check("awaddr", awaddr, t.addr);
                check("awid", awid, t.exp_id);
                check("awlen_size", {awlen, awsize, awburst}, {t.len, t.size, 2'b01});
                check("w_before_aw", wvalid, 0);
            end else begin
                check("arvalid", {arvalid, awvalid}, 2'b10);
                check("araddr", araddr, t.addr);
                check("arid", arid, t.exp_id);
                check("arlen_size", {arlen, arsize, arburst}, {t.len, t.size, 2'b01});
            end
            step();
        end
        arready = 1'b0;
        awready = 1'b0;
        req_valid[other] = 1'b0;
        if (!t.wr) begin
            for (int b = 0; b <= int'(t.len); b++) begin
                d = t.data + 64'(b);
                rvalid = 1'b1; rdata = d; rlast = (b == int'(t.len));
                rresp = (b == t.resp_beat) ? t.resp : 2'b00;
                if (b == t.stall_beat) begin
                    for (int s = 0; s < t.stall; s++) begin
                        rsp_ready[t.who] = 1'b0;
                        #1;
                        check("r_stall_rready", rready, 0);
                        check("r_stall_valid", rsp_valid, oh);
                        step();
                    end
                end
                rsp_ready[t.who] = 1'b1;
                #1;
                check("r_rready", rready, 1);
                check("r_rsp_valid", rsp_valid, oh);
                check("r_data", rsp_data, d);
                check("r_resp", rsp_resp, (b == t.resp_beat) ? t.exp_resp : 2'b00);
                check("r_last", rsp_last, (b == int'(t.len)));
                step();
            end
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rsp_ready = '0;
        end else begin
            for (int b = 0; b <= int'(t.len); b++) begin
                d = t.data + 64'(b);
                wd_valid[t.who] = 1'b1;
                wd_data[t.who*64 +: 64] = d;
                wd_strb[t.who*8 +: 8]   = 8'(b) ^ 8'hFF;
                if (b == t.stall_beat) begin
                    for (int s = 0; s < t.stall; s++) begin
                        wready = 1'b0;
                        #1;
                        check("w_stall_valid", wvalid, 1);
                        check("w_stall_ready", wd_ready, 0);
                        check("w_stall_last", wlast, (b == int'(t.len)));
                        step();
                    end
                end
                wready = 1'b1;
                #1;
                check("w_valid", wvalid, 1);
                check("w_ready", wd_ready, oh);
                check("w_data", wdata, d);
                check("w_strb", wstrb, 8'(b) ^ 8'hFF);
                check("w_last", wlast, (b == int'(t.len)));
                step();
            end
            wd_valid = '0; wready = 1'b0;
            bvalid = 1'b1; bresp = t.resp; rsp_ready[t.who] = 1'b0;
            #1;
            check("b_stall_bready", bready, 0);
            check("b_stall_valid", rsp_valid, oh);
            step();
            rsp_ready[t.who] = 1'b1;
            #1;
            check("b_bready", bready, 1);
            check("b_rsp_valid", rsp_valid, oh);
            check("b_data", rsp_data, 0);
            check("b_resp", rsp_resp, t.exp_resp);
            check("b_last", rsp_last, 1);
            step();
            bvalid = 1'b0; bresp = 2'b00; rsp_ready = '0;
        end
        #1 check("txn_quiet", {rsp_valid, arvalid, awvalid, wvalid}, 0);
    endtask

    // Random traffic against a transaction-level model: busy/owner, a
    // round-robin pointer, and counters of outstanding beats.
    task automatic run_random(input int ncyc, input bit force_both, input int want);
        bit          busy, ar_wait, aw_wait, w_active, b_pend, stop;
        int          owner, r_pend, w_cnt, j;
        logic [7:0]  cur_len;
        logic [31:0] cur_addr;
        logic [2:0]  cur_size;
        logic [N-1:0] exp_rdy, oh;
        int          grants[$];
        busy = 0; ar_wait = 0; aw_wait = 0; w_active = 0; b_pend = 0;
        owner = 0; r_pend = 0; w_cnt = 0;
        cur_len = '0; cur_addr = '0; cur_size = '0;
        for (int cyc = 0; cyc < ncyc + 3000; cyc++) begin
            stop = (cyc >= ncyc) || (want > 0 && grants.size() >= want);
            if (stop && !busy) break;
            req_valid = stop ? '0 : (force_both ? '1 : N'($urandom));
            for (int i = 0; i < N; i++) begin
                req_write[i] = 1'($urandom_range(0, 1));
                req_addr[i*32 +: 32] = $urandom;
                req_size[i*3 +: 3]   = 3'($urandom_range(0, 3));
                req_len[i*8 +: 8]    = 8'($urandom_range(0, 3));
                wd_data[i*64 +: 64]  = {$urandom, $urandom};
                wd_strb[i*8 +: 8]    = 8'($urandom);
            end
            wd_valid  = N'($urandom);
            rsp_ready = N'($urandom);
            arready   = 1'($urandom_range(0, 1));
            awready   = 1'($urandom_range(0, 1));
            wready    = 1'($urandom_range(0, 1));
            rvalid    = (r_pend > 0) && ($urandom_range(0, 1) == 1);
            rlast     = (r_pend == 1);
            rdata     = {$urandom, $urandom};
            rresp     = 2'($urandom_range(0, 3));
            bvalid    = b_pend && ($urandom_range(0, 1) == 1);
            bresp     = 2'($urandom_range(0, 3));
            #1;
            oh = N'(1) << owner;
            exp_rdy = '0;
            if (!busy) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (exp_rdy == '0 && req_valid[j]) exp_rdy = N'(1) << j;
                end
            end
            check("arb_ready", req_ready, exp_rdy);
            check("arb_arvalid", arvalid, ar_wait);
            check("arb_awvalid", awvalid, aw_wait);
            if (ar_wait) check("arb_ar_fields", {arid, araddr, arlen, arsize},
                               {IDW'(owner), cur_addr, cur_len, cur_size});
            if (aw_wait) check("arb_aw_fields", {awid, awaddr, awlen, awsize},
                               {IDW'(owner), cur_addr, cur_len, cur_size});
            check("arb_rready", rready, (r_pend > 0) && rsp_ready[owner]);
            check("arb_bready", bready, b_pend && rsp_ready[owner]);
            check("arb_rsp_route", rsp_valid, (rvalid || bvalid) ? oh : '0);
            check("arb_wvalid", wvalid, w_active && wd_valid[owner]);
            check("arb_wd_ready", wd_ready, (w_active && wready) ? oh : '0);
            if (w_active) begin
                check("arb_wlast", wlast, (w_cnt == int'(cur_len)));
                check("arb_wdata", wdata, wd_data[owner*64 +: 64]);
            end
            if (rvalid) check("arb_rpayload", {rsp_data, rsp_resp, rsp_last}, {rdata, rresp, rlast});
            // advance the model with the handshakes that the coming edge commits
            if (r_pend > 0 && rvalid && rsp_ready[owner]) begin
                r_pend--;
                if (r_pend == 0) begin busy = 0; m_ptr = (owner + 1) % N; end
            end
            if (b_pend && bvalid && rsp_ready[owner]) begin
                b_pend = 0; busy = 0; m_ptr = (owner + 1) % N;
            end
            if (w_active && wd_valid[owner] && wready) begin
                if (w_cnt == int'(cur_len)) begin w_active = 0; b_pend = 1; end
                else w_cnt++;
            end
            if (aw_wait && awready) begin aw_wait = 0; w_active = 1; w_cnt = 0; end
            if (ar_wait && arready) begin ar_wait = 0; r_pend = int'(cur_len) + 1; end
            if (exp_rdy != '0) begin
                for (int k = 0; k < N; k++) if (exp_rdy[k]) owner = k;
                busy = 1;
                grants.push_back(owner);
                cur_addr = req_addr[owner*32 +: 32];
                cur_len  = req_len[owner*8 +: 8];
                cur_size = req_size[owner*3 +: 3];
                if (req_write[owner]) aw_wait = 1; else ar_wait = 1;
            end
            step();
        end
        check("drain_idle", busy, 0);
        if (want > 0) begin
            check("rr_grant_count", grants.size(), want);
            for (int g = 0; g < grants.size(); g++) check("rr_order", grants[g], g % 2);
        end
        idle_inputs();
    endtask

    txn_t tv[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        txn_t pre;
        tv[0] = '{0, 1'b0, 32'h8000_0000, 3'd3, 8'd0,   64'hDEAD_BEEF_0123_4567, 0, -1,  0, -1, 2'b00, 4'd0, 2'b00};
        tv[1] = '{1, 1'b1, 32'h0000_1000, 3'd3, 8'd3,   64'h1111_2222_3333_4444, 1,  2,  2, -1, 2'b00, 4'd1, 2'b00};
        tv[2] = '{0, 1'b0, 32'h4000_0040, 3'd3, 8'd1,   64'hA5A5_5A5A_0F0F_F0F0, 0,  1,  3,  1, 2'b10, 4'd0, 2'b10};
        tv[3] = '{0, 1'b1, 32'h0000_2008, 3'd2, 8'd0,   64'h0BAD_CAFE_0000_0001, 2, -1,  0, -1, 2'b11, 4'd0, 2'b11};
        tv[4] = '{1, 1'b1, 32'h0001_0000, 3'd3, 8'd255, 64'h0000_0000_0000_0100, 0, 100, 1, -1, 2'b00, 4'd1, 2'b00};
        tv[5] = '{1, 1'b0, 32'h0000_3004, 3'd1, 8'd2,   64'h7777_0000_0000_0000, 3,  0,  1,  0, 2'b11, 4'd1, 2'b11};

        // reset state, with both requesters asserting valid during reset
        idle_inputs();
        rst_n = 1'b0;
        req_valid = '1;
        #1 check_all_quiet("reset");
        req_valid = '0;
        step();
        step();
        rst_n = 1'b1;

        // directed transactions
        for (int i = 0; i < $size(tv); i++) run_txn(tv[i]);

        // asynchronous reset in the middle of a read burst
        pre = '{0, 1'b0, 32'h0000_0100, 3'd3, 8'd0, 64'h1, 0, -1, 0, -1, 2'b00, 4'd0, 2'b00};
        run_txn(pre);   // leaves the pointer at requester 1
        req_valid[1] = 1'b1; req_addr[32 +: 32] = 32'h0000_2000; req_len[8 +: 8] = 8'd3; req_size[3 +: 3] = 3'd3;
        #1 check("mid_r_cmd_ready", req_ready, 2'b10);
        step();
        req_valid = '0; arready = 1'b1;
        #1 check("mid_r_arvalid", arvalid, 1);
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = 64'h55; rsp_ready[1] = 1'b1;
        #1 check("mid_r_rsp_valid", rsp_valid, 2'b10);
        step();
        req_valid = '1; wd_valid = '1; bvalid = 1'b1; rsp_ready = '1;
        #2 rst_n = 1'b0;
        #1 check_all_quiet("mid_r_reset");
        step();
        idle_inputs();
        req_valid = '1;
        rst_n = 1'b1;
        #1 check("rr_after_reset", req_ready, 2'b01);
        req_valid = '0;
        step();
        m_ptr = 0;

        // fairness: both requesters continuously valid, six grants
        run_random(1000, 1'b1, 6);
        // general random traffic
        run_random(600, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
